vend_txn_controller: RTL and testbench

- Single-transaction sequencer for the four-item vending machine; it replaces the four parallel per-item coin FSMs with one shared credit accumulator.
- Flow: latch an item selection, check stock, accept 5/10 coins against that item's price, handshake with the dispenser mechanism, then return change as one 5-unit coin pulse per cycle.
- Also handles cancel and inactivity timeout (refund), and keeps per-item stock counters with a restock port.
- Sits between the coin acceptor / keypad front end and the dispenser and coin-hopper drivers.

---
 rtl/vend_pkg.sv | 34 +++
 rtl/vend_stock_bank.sv | 37 +++
 rtl/vend_txn_controller.sv | 157 +++++++++++++++
 tb/tb_vend_txn_controller.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types, constants and price lookup for the vending transaction controller.
package vend_pkg;

  localparam int COIN_UNIT = 5;
  localparam int CREDIT_W  = 6;

  localparam logic [1:0] ITEM_A = 2'd0;
  localparam logic [1:0] ITEM_B = 2'd1;
  localparam logic [1:0] ITEM_C = 2'd2;
  localparam logic [1:0] ITEM_D = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_DISPENSE,
    ST_CHANGE,
    ST_REFUND
  } vend_state_t;

  // Prices arrive as arguments because they are parameters of the instantiating module.
  function automatic logic [CREDIT_W-1:0] price_of(input logic [1:0] item,
                                                   input int pa, input int pb,
                                                   input int pc, input int pd);
    logic [CREDIT_W-1:0] p;
    case (item)
      ITEM_A:  p = CREDIT_W'(pa);
      ITEM_B:  p = CREDIT_W'(pb);
      ITEM_C:  p = CREDIT_W'(pc);
      default: p = CREDIT_W'(pd);
    endcase
    return p;
  endfunction

endpackage

// File: rtl/vend_stock_bank.sv
// Four per-item stock counters: restock load, decrement on vend, floor at zero.
module vend_stock_bank #(
  parameter int STOCK_W = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               restock,
  input  logic [1:0]         restock_item,
  input  logic [STOCK_W-1:0] restock_count,
  input  logic               dec,
  input  logic [1:0]         dec_item,
  output logic [3:0]         stock_empty
);

  logic [STOCK_W-1:0] r_stock [4];

  // Counter update; a restock of the same item overrides a simultaneous decrement.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 4; i++) r_stock[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (restock && (restock_item == 2'(i)))
          r_stock[i] <= restock_count;
        else if (dec && (dec_item == 2'(i)) && (r_stock[i] != '0))
          r_stock[i] <= r_stock[i] - STOCK_W'(1);
      end
    end
  end

  // Empty flags straight from the counters.
  always_comb begin
    stock_empty = '0;
    for (int unsigned i = 0; i < 4; i++) stock_empty[i] = (r_stock[i] == '0);
  end

endmodule

// File: rtl/vend_txn_controller.sv
// Single-transaction vending sequencer with shared credit accumulator,
// cancel/timeout refund, change return and per-item stock.
module vend_txn_controller
  import vend_pkg::*;
#(
  parameter int PRICE_A     = 15,
  parameter int PRICE_B     = 20,
  parameter int PRICE_C     = 25,
  parameter int PRICE_D     = 30,
  parameter int STOCK_W     = 4,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [1:0]         sel,
  input  logic               sel_valid,
  input  logic               coin5,
  input  logic               coin10,
  input  logic               cancel,
  input  logic               dispense_ack,
  input  logic               restock,
  input  logic [1:0]         restock_item,
  input  logic [STOCK_W-1:0] restock_count,
  output logic               busy,
  output logic               sel_reject,
  output logic               dispense_req,
  output logic [1:0]         dispense_item,
  output logic               change5,
  output logic [5:0]         credit,
  output logic [3:0]         stock_empty,
  output logic               done
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TMO_W-1:0]    TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [CREDIT_W-1:0] UNIT     = CREDIT_W'(COIN_UNIT);

  vend_state_t         r_state, w_state_n;
  logic [CREDIT_W-1:0] r_credit, w_credit_n;
  logic [CREDIT_W-1:0] r_price, w_price_n;
  logic [1:0]          r_item, w_item_n;
  logic [TMO_W-1:0]    r_tmo, w_tmo_n;
  logic                r_done, w_done_n;
  logic                w_dec;
  logic                w_coin;
  logic [CREDIT_W-1:0] w_coin_add, w_credit_sum, w_sel_price;
  logic [3:0]          w_empty;

  vend_stock_bank #(.STOCK_W(STOCK_W)) u_stock (
    .clock         (clock),
    .reset         (reset),
    .restock       (restock),
    .restock_item  (restock_item),
    .restock_count (restock_count),
    .dec           (w_dec),
    .dec_item      (r_item),
    .stock_empty   (w_empty)
  );

  // Coin value this cycle and the credit it would produce.
  always_comb begin
    w_coin       = coin5 | coin10;
    w_coin_add   = (coin5 ? UNIT : '0) + (coin10 ? (UNIT + UNIT) : '0);
    w_credit_sum = r_credit + w_coin_add;
    w_sel_price  = price_of(sel, PRICE_A, PRICE_B, PRICE_C, PRICE_D);
  end

  // Next-state and datapath control.
  always_comb begin
    w_state_n  = r_state;
    w_credit_n = r_credit;
    w_price_n  = r_price;
    w_item_n   = r_item;
    w_tmo_n    = r_tmo;
    w_done_n   = 1'b0;
    w_dec      = 1'b0;
    sel_reject = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_credit_n = '0;
        w_tmo_n    = '0;
        if (sel_valid) begin
          if (w_empty[sel]) begin
            sel_reject = 1'b1;
          end else begin
            w_item_n  = sel;
            w_price_n = w_sel_price;
            w_state_n = ST_COLLECT;
          end
        end
      end
      ST_COLLECT: begin
        w_credit_n = w_credit_sum;
        w_tmo_n    = w_coin ? '0 : r_tmo + TMO_W'(1);
        // A coin restarts the idle window, so it also suppresses a timeout this cycle.
        if (cancel || (!w_coin && (r_tmo == TMO_LAST)))
          w_state_n = (w_credit_sum != '0) ? ST_REFUND : ST_IDLE;
        else if (w_credit_sum >= r_price)
          w_state_n = ST_DISPENSE;
      end
      ST_DISPENSE: begin
        if (dispense_ack) begin
          w_dec      = 1'b1;
          w_credit_n = r_credit - r_price;
          if (r_credit == r_price) begin
            w_done_n  = 1'b1;
            w_state_n = ST_IDLE;
          end else begin
            w_state_n = ST_CHANGE;
          end
        end
      end
      ST_CHANGE, ST_REFUND: begin
        w_credit_n = r_credit - UNIT;
        if (r_credit == UNIT) begin
          w_done_n  = 1'b1;
          w_state_n = ST_IDLE;
        end
      end
      default: begin
        w_state_n  = ST_IDLE;
        w_credit_n = '0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_credit <= '0;
      r_price  <= '0;
      r_item   <= '0;
      r_tmo    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_credit <= w_credit_n;
      r_price  <= w_price_n;
      r_item   <= w_item_n;
      r_tmo    <= w_tmo_n;
      r_done   <= w_done_n;
    end
  end

  // Output decode from state.
  always_comb begin
    busy          = (r_state != ST_IDLE);
    dispense_req  = (r_state == ST_DISPENSE);
    change5       = (r_state == ST_CHANGE) || (r_state == ST_REFUND);
    credit        = r_credit;
    dispense_item = r_item;
    stock_empty   = w_empty;
    done          = r_done;
  end

endmodule

// File: tb/tb_vend_txn_controller.sv
// Randomized self-checking bench with a transaction-level reference model.
module tb_vend_txn_controller;

  localparam int STOCK_W = 4;
  localparam int TMO     = 8;
  localparam int PRICE [4] = '{15, 20, 25, 30};

  logic               clock = 1'b0;
  logic               reset;
  logic [1:0]         sel;
  logic               sel_valid, coin5, coin10, cancel, dispense_ack, restock;
  logic [1:0]         restock_item;
  logic [STOCK_W-1:0] restock_count;
  logic               busy, sel_reject, dispense_req, change5, done;
  logic [1:0]         dispense_item;
  logic [5:0]         credit;
  logic [3:0]         stock_empty;

  int n_total = 0;
  int n_bad   = 0;
  int mdl_stock [4];
  int script_q [$];   // coin codes: 0 none, 1 five, 2 ten, 3 both

  vend_txn_controller #(
    .PRICE_A(15), .PRICE_B(20), .PRICE_C(25), .PRICE_D(30),
    .STOCK_W(STOCK_W), .TIMEOUT_CYC(TMO)
  ) dut (
    .clock(clock), .reset(reset), .sel(sel), .sel_valid(sel_valid),
    .coin5(coin5), .coin10(coin10), .cancel(cancel), .dispense_ack(dispense_ack),
    .restock(restock), .restock_item(restock_item), .restock_count(restock_count),
    .busy(busy), .sel_reject(sel_reject), .dispense_req(dispense_req),
    .dispense_item(dispense_item), .change5(change5), .credit(credit),
    .stock_empty(stock_empty), .done(done)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int mdl_empty();
    int e = 0;
    for (int i = 0; i < 4; i++) if (mdl_stock[i] == 0) e |= (1 << i);
    return e;
  endfunction

  // Inputs change at posedge+1; outputs are sampled at the falling edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    sel = '0; sel_valid = 0; coin5 = 0; coin10 = 0; cancel = 0;
    dispense_ack = 0; restock = 0; restock_item = '0; restock_count = '0;
  endtask

  task automatic do_restock(input int item, input int cnt);
    restock = 1; restock_item = 2'(item); restock_count = STOCK_W'(cnt);
    step();
    restock = 0;
    mdl_stock[item] = cnt;
    settle();
    check_val("stock_flags_restock", int'(stock_empty), mdl_empty());
    step();
  endtask

  // One customer transaction. mode 1: a single coin5 then silence (timeout).
  task automatic vend(input int item, input int mode, input int cancel_at, input bit collide);
    int cred, idle, code, add, rem, waitc, rc, price;
    bit paid, ended;
    price = PRICE[item];
    sel = 2'(item); sel_valid = 1;
    settle();
    if (mdl_stock[item] == 0) begin
      check_val("sel_reject_hi", int'(sel_reject), 1);
      check_val("busy_on_reject", int'(busy), 0);
      step();
      sel_valid = 0;
      settle();
      check_val("sel_reject_lo", int'(sel_reject), 0);
      check_val("busy_after_reject", int'(busy), 0);
      step();
      return;
    end
    check_val("sel_accept", int'(sel_reject), 0);
    step();
    sel_valid = 0;
    cred = 0; idle = 0; paid = 0; ended = 0;
    if (mode == 1) script_q.push_back(1);
    for (int c = 0; c < 200; c++) begin
      if (script_q.size() > 0) code = script_q.pop_front();
      else if (mode == 1) code = 0;
      else begin
        code = $urandom_range(0, 5);
        code = (code < 2) ? 0 : (code == 2) ? 1 : (code < 5) ? 2 : 3;
      end
      coin5 = code[0]; coin10 = code[1]; cancel = (c == cancel_at);
      settle();
      check_val("collect_busy", int'(busy), 1);
      check_val("collect_credit", int'(credit), cred);
      check_val("collect_req", int'(dispense_req), 0);
      check_val("collect_change", int'(change5), 0);
      add = (code[0] ? 5 : 0) + (code[1] ? 10 : 0);
      cred += add;
      idle = (add != 0) ? 0 : idle + 1;
      step();
      coin5 = 0; coin10 = 0;
      if (cancel || idle == TMO) begin cancel = 0; ended = 1; break; end
      if (cred >= price) begin paid = 1; break; end
    end
    if (!paid && !ended) check_val("collect_bound", 0, 1);
    rem = cred;
    if (paid) begin
      waitc = $urandom_range(0, 3);
      for (int w = 0; w < waitc; w++) begin
        coin5 = 1'($urandom_range(0, 1)); coin10 = 1'($urandom_range(0, 1));
        cancel = 1'($urandom_range(0, 1));
        settle();
        check_val("disp_req_wait", int'(dispense_req), 1);
        check_val("disp_item", int'(dispense_item), item);
        check_val("disp_credit", int'(credit), cred);
        check_val("disp_change", int'(change5), 0);
        step();
      end
      coin5 = 0; coin10 = 0; cancel = 0;
      dispense_ack = 1;
      rc = $urandom_range(0, 15);
      if (collide) begin
        restock = 1; restock_item = 2'(item); restock_count = STOCK_W'(rc);
      end
      settle();
      check_val("disp_req_ack", int'(dispense_req), 1);
      step();
      dispense_ack = 0; restock = 0;
      if (collide) mdl_stock[item] = rc;
      else if (mdl_stock[item] > 0) mdl_stock[item]--;
      rem = cred - price;
    end
    for (int k = 0; k < rem / 5; k++) begin
      settle();
      check_val("change_pulse", int'(change5), 1);
      check_val("change_credit", int'(credit), rem - 5 * k);
      check_val("change_done_lo", int'(done), 0);
      step();
    end
    settle();
    check_val("end_change_lo", int'(change5), 0);
    check_val("end_busy", int'(busy), 0);
    check_val("end_credit", int'(credit), 0);
    check_val("end_done", int'(done), (paid || rem > 0) ? 1 : 0);
    check_val("end_stock_flags", int'(stock_empty), mdl_empty());
    step();
    settle();
    check_val("done_one_cycle", int'(done), 0);
    step();
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    #1;
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_credit", int'(credit), 0);
    check_val("rst_item", int'(dispense_item), 0);
    check_val("rst_empty", int'(stock_empty), 15);
    check_val("rst_req", int'(dispense_req), 0);
    check_val("rst_change", int'(change5), 0);
    check_val("rst_done", int'(done), 0);
    for (int i = 0; i < 4; i++) mdl_stock[i] = 0;
    repeat (2) step();
    reset = 0;
    step();

    // Exact price, no change.
    do_restock(0, 2);
    script_q = '{2, 1};
    vend(0, 0, -1, 0);
    // Overpay to 40 on item D, two change coins.
    do_restock(3, 1);
    script_q = '{1, 2, 2, 3};
    vend(3, 0, -1, 0);
    // Empty item rejected; coins in IDLE ignored.
    do_restock(2, 0);
    vend(2, 0, -1, 0);
    coin10 = 1; coin5 = 1;
    step();
    coin10 = 0; coin5 = 0;
    settle();
    check_val("idle_coin_credit", int'(credit), 0);
    check_val("idle_coin_busy", int'(busy), 0);
    step();
    // Both coins then cancel: refund 15.
    do_restock(1, 1);
    script_q = '{3, 0};
    vend(1, 0, 1, 0);
    // Inactivity timeout after one coin.
    vend(0, 1, -1, 0);

    // Reset in the middle of collection.
    do_restock(1, 3);
    sel = 2'd1; sel_valid = 1;
    step();
    sel_valid = 0; coin10 = 1;
    step();
    coin10 = 0;
    settle();
    check_val("pre_rst_credit", int'(credit), 10);
    check_val("pre_rst_item", int'(dispense_item), 1);
    reset = 1;
    #1;
    check_val("mid_rst_busy", int'(busy), 0);
    check_val("mid_rst_credit", int'(credit), 0);
    check_val("mid_rst_item", int'(dispense_item), 0);
    check_val("mid_rst_empty", int'(stock_empty), 15);
    check_val("mid_rst_change", int'(change5), 0);
    check_val("mid_rst_done", int'(done), 0);
    for (int i = 0; i < 4; i++) mdl_stock[i] = 0;
    step();
    reset = 0;
    step();
    vend(1, 0, -1, 0);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      int it, md, ca;
      if ($urandom_range(0, 2) == 0) do_restock($urandom_range(0, 3), $urandom_range(0, 3));
      it = $urandom_range(0, 3);
      md = ($urandom_range(0, 5) == 0) ? 1 : 0;
      ca = (md == 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1;
      vend(it, md, ca, ($urandom_range(0, 4) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
